// File: rtl/roll_pkg.sv
// Shared types and schedule helpers for the rolling-number sequencer.
package roll_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Width of a tick counter that must reach the longest interval minus one.
    function automatic int unsigned tick_width(input int unsigned base,
                                               input int unsigned steps,
                                               input int unsigned spl);
        longint unsigned maxv;
        int unsigned     w;
        maxv = 64'(base) << (steps / spl - 1);
        w    = $clog2(maxv);
        return (w < 1) ? 1 : w;
    endfunction

    // The interval doubles every spl samples.
    function automatic longint unsigned interval_ticks(input int unsigned step,
                                                       input int unsigned base,
                                                       input int unsigned spl);
        return 64'(base) << (step / spl);
    endfunction

    localparam int unsigned TICK_W_DEFAULT = tick_width(5_000_000, 16, 4);

endpackage

// File: rtl/roll_scheduler_if.sv
// Button/random-source inputs and display-path outputs of the roll sequencer.
interface roll_scheduler_if #(
    parameter int DATA_W     = 4,
    parameter int NUM_STEPS  = 16,
    parameter int HIST_DEPTH = 4
);
    localparam int STEP_W = $clog2(NUM_STEPS + 1);

    logic                         i_start;
    logic                         i_stop;
    logic [DATA_W-1:0]            i_rand;
    logic [DATA_W-1:0]            o_value;
    logic                         o_sample;
    logic                         o_done;
    logic                         o_busy;
    logic [STEP_W-1:0]            o_step;
    logic [HIST_DEPTH*DATA_W-1:0] o_history;

    modport master (
        output i_start, i_stop, i_rand,
        input  o_value, o_sample, o_done, o_busy, o_step, o_history
    );

    modport slave (
        input  i_start, i_stop, i_rand,
        output o_value, o_sample, o_done, o_busy, o_step, o_history
    );
endinterface

// File: rtl/roll_history.sv
// Shift register of final roll results, newest in the low slot.
// One-cycle latency from push to visible entry; push always accepted, clear wins.
module roll_history #(
    parameter int DATA_W     = 4,
    parameter int HIST_DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_clr,
    input  logic                         i_push,
    input  logic [DATA_W-1:0]            i_data,
    output logic [HIST_DEPTH*DATA_W-1:0] o_hist
);
    logic [HIST_DEPTH*DATA_W-1:0] hist_q;

    generate
        if (HIST_DEPTH > 1) begin : g_shift
            always_ff @(posedge i_clk) begin
                if (i_clr) begin
                    hist_q <= '0;
                end else if (i_push) begin
                    hist_q <= {hist_q[(HIST_DEPTH-1)*DATA_W-1:0], i_data};
                end
            end
        end else begin : g_single
            always_ff @(posedge i_clk) begin
                if (i_clr) begin
                    hist_q <= '0;
                end else if (i_push) begin
                    hist_q <= i_data;
                end
            end
        end
    endgenerate

    assign o_hist = hist_q;
endmodule

// File: rtl/roll_scheduler.sv
// Rolling-number sequencer: samples i_rand on a doubling interval, settles, then locks out.
// All outputs registered (busy decoded from state register); inputs are never backpressured.
module roll_scheduler
    import roll_pkg::*;
#(
    parameter int DATA_W          = 4,
    parameter int BASE_TICKS      = 5_000_000,
    parameter int NUM_STEPS       = 16,
    parameter int STEPS_PER_LEVEL = 4,
    parameter int HOLD_TICKS      = 50_000_000,
    parameter int HIST_DEPTH      = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    roll_scheduler_if.slave  bus
);
    localparam int TICK_W = int'(tick_width(BASE_TICKS, NUM_STEPS, STEPS_PER_LEVEL));
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int STEP_W = $clog2(NUM_STEPS + 1);

    state_t                       state_q, state_d;
    logic [TICK_W-1:0]            tick_q, tick_d;
    logic [HOLD_W-1:0]            hold_q, hold_d;
    logic [STEP_W-1:0]            step_q, step_d;
    logic [DATA_W-1:0]            value_q, value_d;
    logic                         sample_q, sample_d;
    logic                         done_q, done_d;
    logic                         push;
    logic                         tick_hit;
    logic                         last_step;
    logic                         hold_end;
    logic [63:0]                  cur_interval;
    logic [HIST_DEPTH*DATA_W-1:0] hist;

    assign cur_interval = interval_ticks(32'(step_q), BASE_TICKS, STEPS_PER_LEVEL);
    assign tick_hit     = (64'(tick_q) == (cur_interval - 64'd1));
    assign last_step    = (step_q == STEP_W'(NUM_STEPS - 1));
    assign hold_end     = (hold_q == HOLD_W'(HOLD_TICKS - 1));

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        hold_d   = hold_q;
        step_d   = step_q;
        value_d  = value_q;
        sample_d = 1'b0;
        done_d   = 1'b0;
        push     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d = S_RUN;
                    tick_d  = '0;
                    step_d  = '0;
                end
            end

            S_RUN: begin
                // A stop landing on a scheduled capture still yields one capture.
                if (tick_hit || bus.i_stop) begin
                    value_d  = bus.i_rand;
                    sample_d = 1'b1;
                    step_d   = step_q + STEP_W'(1);
                    tick_d   = '0;
                    if (bus.i_stop || last_step) begin
                        done_d  = 1'b1;
                        push    = 1'b1;
                        state_d = S_HOLD;
                        hold_d  = '0;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            S_HOLD: begin
                // The lockout's final edge already accepts a new start.
                if (hold_end) begin
                    hold_d = '0;
                    if (bus.i_start) begin
                        state_d = S_RUN;
                        tick_d  = '0;
                        step_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            hold_q   <= '0;
            step_q   <= '0;
            value_q  <= '0;
            sample_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            hold_q   <= hold_d;
            step_q   <= step_d;
            value_q  <= value_d;
            sample_q <= sample_d;
            done_q   <= done_d;
        end
    end

    roll_history #(
        .DATA_W     (DATA_W),
        .HIST_DEPTH (HIST_DEPTH)
    ) u_history (
        .i_clk  (i_clk),
        .i_clr  (i_rst),
        .i_push (push),
        .i_data (value_d),
        .o_hist (hist)
    );

    assign bus.o_value   = value_q;
    assign bus.o_sample  = sample_q;
    assign bus.o_done    = done_q;
    assign bus.o_busy    = (state_q != S_IDLE);
    assign bus.o_step    = step_q;
    assign bus.o_history = hist;
endmodule

// File: tb/tb_roll_scheduler.sv
// Directed bench for roll_scheduler with short schedule parameters.
module tb_roll_scheduler;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    roll_scheduler_if #(.DATA_W(4), .NUM_STEPS(8), .HIST_DEPTH(4)) rif ();

    roll_scheduler #(
        .DATA_W          (4),
        .BASE_TICKS      (3),
        .NUM_STEPS       (8),
        .STEPS_PER_LEVEL (4),
        .HOLD_TICKS      (5),
        .HIST_DEPTH      (4)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (rif)
    );

    int          checks     = 0;
    int          failures   = 0;
    int          e          = 0;
    int          rand_force = -1;
    logic [3:0]  edge_rand  = 4'd0;
    logic [3:0]  mdl_value  = 4'd0;
    int          mdl_step   = 0;
    logic [15:0] exp_hist   = 16'h0;
    int          cap_rel[8] = '{3, 6, 9, 12, 18, 24, 30, 36};

    // i_rand equals the edge index mod 16 unless forced; sample 1 time unit after the edge.
    task automatic clk_step();
        rif.i_rand = (rand_force >= 0) ? 4'(rand_force) : 4'((e + 1) % 16);
        edge_rand  = rif.i_rand;
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic apply_reset();
        rst         = 1'b1;
        rif.i_start = 1'b0;
        rif.i_stop  = 1'b0;
        clk_step();
        clk_step();
        rst       = 1'b0;
        mdl_value = 4'd0;
        mdl_step  = 0;
        exp_hist  = 16'h0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        rif.i_start = 1'b0;
        rif.i_stop  = 1'b0;
        clk_step();
        clk_step();
        checks++; if (rif.o_value !== 4'd0) begin failures++; $display("FAIL reset_value got=%h exp=0", rif.o_value); end
        checks++; if (rif.o_sample !== 1'b0) begin failures++; $display("FAIL reset_sample got=%b exp=0", rif.o_sample); end
        checks++; if (rif.o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", rif.o_done); end
        checks++; if (rif.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", rif.o_busy); end
        checks++; if (rif.o_step !== 4'd0) begin failures++; $display("FAIL reset_step got=%0d exp=0", rif.o_step); end
        checks++; if (rif.o_history !== 16'h0) begin failures++; $display("FAIL reset_history got=%h exp=0", rif.o_history); end
        rst = 1'b0;
    endtask

    // Starts a roll, optionally stops it and pulses start at given relative edges, and
    // checks every cycle through the lockout plus one edge that may start the next roll.
    task automatic run_roll(input string name, input int stop_rel, input int start_a,
                            input int start_b, input int final_rel, input bit accept_end);
        bit cap;
        rif.i_start = 1'b1;
        clk_step();
        rif.i_start = 1'b0;
        mdl_step    = 0;
        checks++; if (rif.o_busy !== 1'b1) begin failures++; $display("FAIL %s start_busy got=%b exp=1", name, rif.o_busy); end
        checks++; if (rif.o_step !== 4'd0) begin failures++; $display("FAIL %s start_step got=%0d exp=0", name, rif.o_step); end
        for (int rel = 1; rel <= final_rel + 4; rel++) begin
            rif.i_stop  = (rel == stop_rel);
            rif.i_start = (rel == start_a) || (rel == start_b);
            clk_step();
            rif.i_stop  = 1'b0;
            rif.i_start = 1'b0;
            cap = (rel == final_rel);
            foreach (cap_rel[i]) if (cap_rel[i] == rel && rel <= final_rel) cap = 1'b1;
            if (cap) begin
                mdl_step++;
                mdl_value = edge_rand;
            end
            if (rel == final_rel) exp_hist = {exp_hist[11:0], edge_rand};
            checks++; if (rif.o_sample !== cap) begin failures++; $display("FAIL %s sample rel=%0d got=%b exp=%b", name, rel, rif.o_sample, cap); end
            checks++; if (rif.o_done !== (rel == final_rel)) begin failures++; $display("FAIL %s done rel=%0d got=%b", name, rel, rif.o_done); end
            checks++; if (rif.o_busy !== 1'b1) begin failures++; $display("FAIL %s busy rel=%0d got=%b exp=1", name, rel, rif.o_busy); end
            checks++; if (rif.o_value !== mdl_value) begin failures++; $display("FAIL %s value rel=%0d got=%h exp=%h", name, rel, rif.o_value, mdl_value); end
            checks++; if (rif.o_step !== 4'(mdl_step)) begin failures++; $display("FAIL %s step rel=%0d got=%0d exp=%0d", name, rel, rif.o_step, mdl_step); end
            checks++; if (rif.o_history !== exp_hist) begin failures++; $display("FAIL %s history rel=%0d got=%h exp=%h", name, rel, rif.o_history, exp_hist); end
        end
        rif.i_start = accept_end;
        clk_step();
        rif.i_start = 1'b0;
        if (accept_end) mdl_step = 0;
        checks++; if (rif.o_busy !== accept_end) begin failures++; $display("FAIL %s end_busy got=%b exp=%b", name, rif.o_busy, accept_end); end
        checks++; if (rif.o_sample !== 1'b0) begin failures++; $display("FAIL %s end_sample got=%b exp=0", name, rif.o_sample); end
        checks++; if (rif.o_step !== 4'(mdl_step)) begin failures++; $display("FAIL %s end_step got=%0d exp=%0d", name, rif.o_step, mdl_step); end
    endtask

    // Expects the first capture of a freshly started roll exactly three edges later.
    task automatic expect_first_capture(input string name);
        for (int rel = 1; rel <= 3; rel++) begin
            clk_step();
            checks++; if (rif.o_sample !== (rel == 3)) begin failures++; $display("FAIL %s first_sample rel=%0d got=%b", name, rel, rif.o_sample); end
            checks++; if (rif.o_done !== 1'b0) begin failures++; $display("FAIL %s first_done rel=%0d got=%b exp=0", name, rel, rif.o_done); end
        end
        checks++; if (rif.o_value !== edge_rand) begin failures++; $display("FAIL %s first_value got=%h exp=%h", name, rif.o_value, edge_rand); end
        checks++; if (rif.o_step !== 4'd1) begin failures++; $display("FAIL %s first_step got=%0d exp=1", name, rif.o_step); end
    endtask

    task automatic test_full_roll();
        run_roll("full_roll", 0, 0, 0, 36, 1'b0);
        checks++; if (rif.o_step !== 4'd8) begin failures++; $display("FAIL full_roll final_step got=%0d exp=8", rif.o_step); end
    endtask

    task automatic test_early_stop();
        run_roll("early_stop", 7, 0, 0, 7, 1'b0);
    endtask

    task automatic test_stop_on_capture();
        run_roll("stop_on_capture", 9, 0, 0, 9, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_roll("start_ignored", 0, 5, 38, 36, 1'b1);
        expect_first_capture("restart_after_hold");
        apply_reset();
    endtask

    task automatic test_idle_inputs();
        rif.i_stop = 1'b1;
        clk_step();
        rif.i_stop = 1'b0;
        checks++; if (rif.o_busy !== 1'b0) begin failures++; $display("FAIL idle_stop busy got=%b exp=0", rif.o_busy); end
        checks++; if (rif.o_sample !== 1'b0) begin failures++; $display("FAIL idle_stop sample got=%b exp=0", rif.o_sample); end
        rif.i_start = 1'b1;
        rif.i_stop  = 1'b1;
        clk_step();
        rif.i_start = 1'b0;
        rif.i_stop  = 1'b0;
        checks++; if (rif.o_busy !== 1'b1) begin failures++; $display("FAIL start_and_stop busy got=%b exp=1", rif.o_busy); end
        checks++; if (rif.o_sample !== 1'b0) begin failures++; $display("FAIL start_and_stop sample got=%b exp=0", rif.o_sample); end
        expect_first_capture("start_and_stop");
        apply_reset();
    endtask

    task automatic test_reset_midroll();
        run_roll("pre_reset", 2, 0, 0, 2, 1'b0);
        rif.i_start = 1'b1;
        clk_step();
        rif.i_start = 1'b0;
        for (int rel = 1; rel < 20; rel++) clk_step();
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        checks++; if (rif.o_value !== 4'd0) begin failures++; $display("FAIL midreset_value got=%h exp=0", rif.o_value); end
        checks++; if (rif.o_sample !== 1'b0) begin failures++; $display("FAIL midreset_sample got=%b exp=0", rif.o_sample); end
        checks++; if (rif.o_done !== 1'b0) begin failures++; $display("FAIL midreset_done got=%b exp=0", rif.o_done); end
        checks++; if (rif.o_busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", rif.o_busy); end
        checks++; if (rif.o_step !== 4'd0) begin failures++; $display("FAIL midreset_step got=%0d exp=0", rif.o_step); end
        checks++; if (rif.o_history !== 16'h0) begin failures++; $display("FAIL midreset_history got=%h exp=0", rif.o_history); end
        rif.i_start = 1'b1;
        clk_step();
        rif.i_start = 1'b0;
        expect_first_capture("after_midreset");
        apply_reset();
    endtask

    task automatic test_history();
        for (int v = 1; v <= 4; v++) begin
            rand_force = v;
            run_roll("history", 1, 0, 0, 1, 1'b0);
        end
        checks++; if (rif.o_history !== 16'h1234) begin failures++; $display("FAIL history_four got=%h exp=1234", rif.o_history); end
        rand_force = 5;
        run_roll("history", 1, 0, 0, 1, 1'b0);
        rand_force = -1;
        checks++; if (rif.o_history !== 16'h2345) begin failures++; $display("FAIL history_five got=%h exp=2345", rif.o_history); end
    endtask

    initial begin
        rst         = 1'b1;
        rif.i_start = 1'b0;
        rif.i_stop  = 1'b0;
        rif.i_rand  = 4'd0;
        test_reset();
        test_full_roll();
        test_early_stop();
        test_stop_on_capture();
        test_start_ignored();
        test_idle_inputs();
        test_reset_midroll();
        test_history();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/roll_scheduler.md
# roll_scheduler

Sequencing controller for the board's rolling-number generator: on a start request it strobes samples from the free-running random source at a decelerating schedule, settles on a final value, and keeps a short history of results. It sits between the debounced push-button inputs and the free-running random counter. It drives the 7-segment/LED display path through `o_value` and `o_sample`.

## Interface
Parameters:
- `DATA_W`, 4: width of random value.
- `BASE_TICKS`, 5_000_000: clock cycles in the shortest sample interval; ≥ 1.
- `NUM_STEPS`, 16: samples per full roll; a multiple of `STEPS_PER_LEVEL`.
- `STEPS_PER_LEVEL`, 4: samples taken before the interval doubles.
- `HOLD_TICKS`, 50_000_000: lockout cycles after a roll settles; ≥ 1.
- `HIST_DEPTH`, 4: number of stored final results.

Ports:
- `i_clk`, in, 1: the design's single clock.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_start`, in, 1: start request, sampled every cycle.
- `i_stop`, in, 1: early-settle request.
- `i_rand`, in, `DATA_W`: free-running random source.
- `o_value`, out, `DATA_W`: last sampled value.
- `o_sample`, out, 1: one-cycle pulse; `o_value` changed this cycle.
- `o_done`, out, 1: one-cycle pulse; final value captured.
- `o_busy`, out, 1: high in RUN and HOLD.
- `o_step`, out, `$clog2(NUM_STEPS+1)`: samples taken in the current or last roll.
- `o_history`, out, `HIST_DEPTH*DATA_W`: final values. Bits `[DATA_W-1:0]` hold the newest.

## Operation
- States: S_IDLE, S_RUN, S_HOLD.
- Interval for step k (0-based) = `BASE_TICKS << (k / STEPS_PER_LEVEL)`.
- The tick counter is wide enough for the largest interval, `$clog2(BASE_TICKS << (NUM_STEPS/STEPS_PER_LEVEL - 1))` bits, and never wraps.
- **S_IDLE:**
  - `i_start` → S_RUN with tick=0, step=0, `o_step`=0.
  - `i_stop` is ignored.
  - When `i_start` and `i_stop` are high together, start wins and stop is discarded.
- **S_RUN:**
  - tick increments each cycle.
  - When tick == interval(step)−1, capture at that edge: `o_value`←`i_rand`, `o_sample`←1, `o_step`++, tick←0, step++.
  - A capture with step == NUM_STEPS−1 is final. It also sets `o_done`←1, shifts `o_value` into `o_history` (oldest dropped), and moves to S_HOLD with hold=0.
  - `i_stop` high in S_RUN forces a final capture at that edge, regardless of tick.
  - When `i_stop` coincides with a scheduled capture, exactly one final capture occurs and `o_step` increments once.
  - `i_start` is ignored; a roll in progress cannot restart.
- **S_HOLD:**
  - hold increments each cycle; when hold == HOLD_TICKS−1, go to S_IDLE.
  - `i_start` and `i_stop` are ignored.
  - `o_value` and `o_step` hold their values.
- **Reset** (including mid-roll):
  - state S_IDLE; all counters 0.
  - Outputs `o_value`, `o_sample`, `o_done`, `o_busy`, `o_step` and `o_history` all go to 0.

## Timing
- All outputs are registered. `o_busy` is decoded from the registered state.
- `i_start` sampled at edge E gives `o_busy`=1 in the cycle after E.
- The first capture occurs at edge E+BASE_TICKS.
- Capture n (1-based) occurs at edge E + Σ interval(0..n−1).
- `o_sample` and `o_done` are high for exactly the one cycle following their capture edge.
- The final capture is at edge F. S_IDLE is reached and `o_busy` falls after edge F+HOLD_TICKS. The earliest accepted new `i_start` is at edge F+HOLD_TICKS.
- Full-roll length is `BASE_TICKS*STEPS_PER_LEVEL*(2^(NUM_STEPS/STEPS_PER_LEVEL)−1)` cycles.

## Structure
- Package `roll_pkg`:
  - state enum (S_IDLE, S_RUN, S_HOLD);
  - function `interval_ticks(step)`;
  - localparam for the tick-counter width.
- Sub-module `roll_history`: a `HIST_DEPTH`×`DATA_W` shift register with push enable and synchronous clear, exposing the packed vector.
- The top level holds the FSM, tick/hold counters and output registers.

## Test plan
Bench parameters: BASE_TICKS=3, NUM_STEPS=8, STEPS_PER_LEVEL=4, HOLD_TICKS=5, DATA_W=4, HIST_DEPTH=4.
- Full roll: `i_start` at edge E, with `i_rand`=edge index mod 16 → captures at E+3,6,9,12,18,24,30,36. `o_done` high only after E+36; `o_step`=8; `o_history[3:0]`=(E+36) mod 16; `o_busy` falls after E+41.
- Early stop: `i_stop` at E+7 → capture at E+7 with `o_done`=1 and `o_step`=3. No further `o_sample`; S_IDLE after E+12.
- Stop coinciding with the scheduled capture at E+9 → single `o_sample`/`o_done` pulse; `o_step`=3.
- `i_start` pulses during RUN and during HOLD → no restart, schedule unchanged. A start at edge F+5 is accepted.
- Four rolls with final values 1,2,3,4 then a fifth with 5 → `o_history`=16'h2345.
- Reset asserted at E+20 mid-roll → all outputs 0 next cycle. A new `i_start` gives its first capture exactly 3 cycles later.
